vc_input_arbiter: RTL
=====================

// Module: vc_input_arbiter
// PURPOSE
// - Per-input-port arbiter: picks one of VN=vc_num*prio_num input VCs holding a packet, requests its
//   (dest, output VC) from the switch allocator, holds the grant until the packet's last beat.
// - Sits between the per-VC input buffers (has_packet/dest_i/output_vc_i) and the crossbar allocator (cts).
// - Strict priority across classes; round-robin among VCs of the same class.
// PARAMETERS
// - vc_num      3   VCs per priority class
// - prio_num    2   priority classes; VC v has class v/vc_num; higher class index = higher priority
// - output_num  8   switch outputs; width of dest = $clog2(output_num)
// - STARVE_MAX  15  (starvation guard only) consecutive higher-class grants before forced service
// PORTS
// - clk          in   1                       clock
// - resetn       in   1                       async active-low reset
// - has_packet   in   VN                      bit v=1: VC v holds a packet head
// - dest_i       in   VN x $clog2(output_num) destination output per VC
// - output_vc_i  in   VN x $clog2(VN)         requested output VC per VC
// - cts          in   1                       allocator grant for the current request
// - last         in   1                       last beat of the granted packet crosses this cycle
// - o_req        out  1                       request valid to allocator
// - o_req_dest   out  $clog2(output_num)      destination of requesting VC
// - o_req_out_vc out  $clog2(VN)              output VC of requesting VC
// - selected_vc  out  $clog2(VN)              VC currently selected/granted
// - o_granted    out  1                       high while packet of selected_vc is transferring
// BEHAVIOUR
// - Clock clk; reset resetn asynchronous, active-low. Reset: state IDLE, all outputs 0, RR pointers 0,
//   starvation counters 0. Reset mid-packet aborts silently; no last is required afterwards.
// - FSM IDLE -> REQ -> XFER -> IDLE.
// - IDLE: if |has_packet, choose winner = highest non-empty class, within it first set bit at/after that
//   class's RR pointer (wrap-around). Register winner into selected_vc, latch dest_i/output_vc_i of the
//   winner into o_req_dest/o_req_out_vc; go REQ. Selection latency 1 cycle (o_req high cycle after has_packet).
// - REQ: o_req=1, selected_vc/dest/out_vc stable. cts=1 -> XFER next cycle (o_req drops, o_granted=1).
//   has_packet[selected_vc]=0 while cts=0 -> withdraw: IDLE next cycle, pointer unchanged.
//   cts and withdraw in same cycle: cts wins (XFER). No re-arbitration in REQ even if higher class arrives.
// - XFER: o_granted=1. last=1 -> IDLE next cycle; RR pointer of winner's class <= winner_local+1 mod vc_num.
//   cts and has_packet ignored in XFER. last ignored outside XFER.
// - Mandatory 1-cycle IDLE bubble between packets; back-to-back XFER->REQ not permitted.
// - Single-beat packet: last may be high on the first XFER cycle.
// - o_req_dest/o_req_out_vc retain value after XFER until next selection.
// CONFIGURATION
// - Macro VC_INPUT_ARB_STARVE_GUARD_EN.
// - Defined: per lower class a 4-bit saturating counter ($clog2(STARVE_MAX+1)) increments on each XFER
//   entry of a higher class while that class has a pending VC; on reaching STARVE_MAX the highest such
//   starved class wins the next IDLE selection; counter clears when that class enters XFER.
// - Undefined: pure strict priority; counters and STARVE_MAX absent from logic.
// STRUCTURE
// - Package vc_arb_pkg: state enum {IDLE,REQ,XFER} (2-bit), vc_idx_t/dest_t widths helper,
//   function rr_first(req,ptr) rotating find-first.
// - Sub-module rr_class_picker: one per class (generate), combinational rotate-find-first over vc_num
//   bits plus registered pointer update on last; top does class priority + FSM.
// TESTING
// - Reset: has_packet=6'b111111 held during resetn=0 -> o_req=0,o_granted=0; o_req=1 selected_vc=3 two
//   cycles after resetn rises (class 1 wins).
// - RR: has_packet=6'b000111 constant, cts 1 cycle after o_req, last after 3 beats -> selected_vc sequence
//   0,1,2,0; one IDLE cycle between packets.
// - Priority: has_packet=6'b000001 then bit4 set during REQ for VC0 -> VC0 completes; next selection VC4.
// - Withdraw: VC2 in REQ, cts=0, has_packet[2] falls -> IDLE next cycle, o_req=0; next selection VC2 again
//   if re-asserted (pointer unchanged).
// - Routing: dest_i[5]=7, output_vc_i[5]=4, has_packet=6'b100000 -> o_req_dest=7, o_req_out_vc=4;
//   cts+last same cycle as XFER entry -> 1-cycle o_granted.
// - Guard (macro on, STARVE_MAX=15): has_packet=6'b001001 constant -> VC0 granted on the 16th packet;
//   macro off -> VC0 never granted in 100 packets.

Source files
------------

// File: rtl/vc_arb_pkg.sv
// Shared types and helpers for the per-input-port VC arbiter.
// Optional starvation guard is selected by VC_INPUT_ARB_STARVE_GUARD_EN (see vc_input_arbiter).
package vc_arb_pkg;

    localparam int DEF_VC_NUM     = 3;
    localparam int DEF_PRIO_NUM   = 2;
    localparam int DEF_OUTPUT_NUM = 8;
    localparam int DEF_VN         = DEF_VC_NUM * DEF_PRIO_NUM;
    localparam int VC_IDX_W       = $clog2(DEF_VN);
    localparam int DEST_W         = $clog2(DEF_OUTPUT_NUM);

    // Widest class the rotating picker supports.
    localparam int MAX_VC   = 16;
    localparam int MAX_VC_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    typedef logic [VC_IDX_W-1:0] vc_idx_t;
    typedef logic [DEST_W-1:0]   dest_t;

    typedef struct packed {
        logic                found;
        logic [MAX_VC_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req[n-1:0] at or after ptr, wrapping around.
    function automatic rr_pick_t rr_first(input logic [MAX_VC-1:0] req, input int n, input int ptr);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int i = 0; i < MAX_VC; i++) begin
            idx = unsigned'((ptr + i) % n);
            if (i < n && !res.found && req[idx[MAX_VC_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[MAX_VC_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_class_picker.sv
// Round-robin picker for the VCs of one priority class; pointer advances
// past the winner when its packet finishes.
module rr_class_picker
    import vc_arb_pkg::*;
#(
    parameter int N  = DEF_VC_NUM,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [N-1:0]  i_req,
    input  logic          i_upd,
    input  logic [LW-1:0] i_upd_idx,
    output logic          o_found,
    output logic [LW-1:0] o_idx
);

    logic [LW-1:0] r_ptr;
    rr_pick_t      w_pick;

    assign w_pick  = rr_first(MAX_VC'(i_req), N, int'(r_ptr));
    assign o_found = w_pick.found;
    assign o_idx   = LW'(w_pick.idx);

    // Next search starts just after the VC that completed a packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_ptr <= '0;
        else if (i_upd)
            r_ptr <= (i_upd_idx == LW'(N - 1)) ? '0 : i_upd_idx + 1'b1;
    end

endmodule

// File: rtl/vc_input_arbiter.sv
// Per-input-port VC arbiter: strict priority between classes, round-robin
// inside a class, grant held from allocator cts until the packet's last beat.
// Define VC_INPUT_ARB_STARVE_GUARD_EN to let a lower class that has been
// bypassed STARVE_MAX times win the next selection.
module vc_input_arbiter
    import vc_arb_pkg::*;
#(
    parameter int vc_num     = DEF_VC_NUM,
    parameter int prio_num   = DEF_PRIO_NUM,
    parameter int output_num = DEF_OUTPUT_NUM,
`ifdef VC_INPUT_ARB_STARVE_GUARD_EN
    parameter int STARVE_MAX = 15,
`endif
    localparam int VN = vc_num * prio_num,
    localparam int VW = $clog2(VN),
    localparam int DW = $clog2(output_num)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [VN-1:0]         has_packet,
    input  logic [VN-1:0][DW-1:0] dest_i,
    input  logic [VN-1:0][VW-1:0] output_vc_i,
    input  logic                  cts,
    input  logic                  last,
    output logic                  o_req,
    output logic [DW-1:0]         o_req_dest,
    output logic [VW-1:0]         o_req_out_vc,
    output logic [VW-1:0]         selected_vc,
    output logic                  o_granted
);

    localparam int LW = (vc_num > 1) ? $clog2(vc_num) : 1;
    localparam int CW = (prio_num > 1) ? $clog2(prio_num) : 1;

    arb_state_t                   r_state;
    logic [CW-1:0]                r_sel_cls;
    logic [LW-1:0]                r_sel_loc;
    logic [prio_num-1:0]          w_cls_found;
    logic [prio_num-1:0][LW-1:0]  w_cls_idx;
    logic [prio_num-1:0]          w_upd;
    logic                         w_win_found;
    logic [CW-1:0]                w_win_cls;
    logic [LW-1:0]                w_win_loc;
    logic [VW-1:0]                w_win_vc;

    for (genvar c = 0; c < prio_num; c++) begin : g_cls
        assign w_upd[c] = (r_state == XFER) && last && (r_sel_cls == CW'(c));
        rr_class_picker #(.N(vc_num), .LW(LW)) u_pick (
            .clk       (clk),
            .resetn    (resetn),
            .i_req     (has_packet[c*vc_num +: vc_num]),
            .i_upd     (w_upd[c]),
            .i_upd_idx (r_sel_loc),
            .o_found   (w_cls_found[c]),
            .o_idx     (w_cls_idx[c])
        );
    end

`ifdef VC_INPUT_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [prio_num-2:0][SW-1:0] r_starve;

    // Count higher-class grants taken while a lower class waits; clear when it is served.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve <= '0;
        end else if (r_state == REQ && cts) begin
            for (int c = 0; c < prio_num - 1; c++) begin
                if (r_sel_cls == CW'(c))
                    r_starve[c] <= '0;
                else if (int'(r_sel_cls) > c && w_cls_found[c] && r_starve[c] != SW'(STARVE_MAX))
                    r_starve[c] <= r_starve[c] + 1'b1;
            end
        end
    end
`endif

    // Highest non-empty class wins (a starved class overrides when guarded).
    always_comb begin
        w_win_found = 1'b0;
        w_win_cls   = '0;
        for (int c = 0; c < prio_num; c++) begin
            if (w_cls_found[c]) begin
                w_win_found = 1'b1;
                w_win_cls   = CW'(c);
            end
        end
`ifdef VC_INPUT_ARB_STARVE_GUARD_EN
        for (int c = 0; c < prio_num - 1; c++) begin
            if (w_cls_found[c] && r_starve[c] == SW'(STARVE_MAX))
                w_win_cls = CW'(c);
        end
`endif
        w_win_loc = w_cls_idx[w_win_cls];
        w_win_vc  = VW'(int'(w_win_cls) * vc_num + int'(w_win_loc));
    end

    // IDLE -> REQ -> XFER -> IDLE with registered request/grant outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_sel_cls    <= '0;
            r_sel_loc    <= '0;
            o_req        <= 1'b0;
            o_granted    <= 1'b0;
            o_req_dest   <= '0;
            o_req_out_vc <= '0;
            selected_vc  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_found) begin
                        r_state      <= REQ;
                        o_req        <= 1'b1;
                        selected_vc  <= w_win_vc;
                        r_sel_cls    <= w_win_cls;
                        r_sel_loc    <= w_win_loc;
                        o_req_dest   <= dest_i[w_win_vc];
                        o_req_out_vc <= output_vc_i[w_win_vc];
                    end
                end
                REQ: begin
                    // A grant beats a simultaneous withdraw.
                    if (cts) begin
                        r_state   <= XFER;
                        o_req     <= 1'b0;
                        o_granted <= 1'b1;
                    end else if (!has_packet[selected_vc]) begin
                        r_state <= IDLE;
                        o_req   <= 1'b0;
                    end
                end
                XFER: begin
                    if (last) begin
                        r_state   <= IDLE;
                        o_granted <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
